// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared fetch types, constants and PC helpers
package instr_fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem request/response, redirect and decode channels of the fetch unit
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// instr_fetch_unit_fifo: synchronous FIFO of fetch entries; flush and reset win over push
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk)
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues credit-limited in-order imem requests and
// buffers tagged instructions for decode; redirects flush and drop in-flight responses
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [XLEN-1:0] fetch_pc, rsp_pc;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count;
    logic [CW:0] in_use;
    logic fifo_full, fifo_empty, req_fire, rsp_keep, pop;
    fetch_entry_t head, rsp_entry;
    assign in_use = {1'b0, fifo_count} + {1'b0, outstanding};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && in_use < (CW+1)'(FIFO_DEPTH);
    assign bus.imem_req_addr = fetch_pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep = bus.imem_rsp_valid && !bus.redirect_valid && drop_cnt == '0;
    assign rsp_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};
    assign bus.inst_valid = !rst && !fifo_empty;
    assign bus.inst_data = fifo_empty ? INSTR_NOP : head.instr;
    assign bus.inst_pc = head.pc;
    assign pop = bus.inst_valid && bus.inst_ready;
    // outstanding counts every in-flight request, including those already marked for dropping,
    // so on redirect everything still in flight (minus the response arriving now) must be dropped
    always_ff @(posedge clk)
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                fetch_pc <= align_pc(bus.redirect_pc);
                rsp_pc <= align_pc(bus.redirect_pc);
                drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_keep) rsp_pc <= rsp_pc + PC_STEP;
                if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    instr_fetch_unit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(rsp_keep),
        .din(rsp_entry),
        .pop(pop),
        .flush(bus.redirect_valid),
        .dout(head),
        .count(fifo_count),
        .full(fifo_full),
        .empty(fifo_empty)
    );
    a_rsp_without_req: assert property (@(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> outstanding != '0);
    a_push_when_full: assert property (@(posedge clk) disable iff (rst) rsp_keep |-> !fifo_full);
endmodule
